// File: rtl/dsp_mux_pkg.sv
// Shared definitions for the scan channel mux: mode encodings, default sizes, clog2 helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dsp_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_CHANNELS = 14;

  // Bits needed to index n items (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_channel.sv
// Finds the next enabled channel strictly after ptr, wrapping CHANNELS-1 -> 0; ptr itself is the last candidate.
// Latency: combinational.
// Backpressure: none (pure function of ptr and mask).
module rr_next_channel #(
  parameter int CHANNELS = 14,
  parameter int SEL_W    = 4
) (
  input  logic [SEL_W-1:0]    ptr_i,
  input  logic [CHANNELS-1:0] mask_i,
  output logic [SEL_W-1:0]    nxt_o,
  output logic                any_en_o
);

  // ptr + off reduced modulo CHANNELS; off never exceeds CHANNELS so one subtraction suffices.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  // Walk from the farthest offset to the nearest so the nearest enabled channel wins.
  always_comb begin
    nxt_o = ptr_i;
    for (int off = CHANNELS; off >= 1; off--) begin
      if (mask_i[wrap_add(ptr_i, off)]) nxt_o = wrap_add(ptr_i, off);
    end
  end

  assign any_en_o = |mask_i;

endmodule

// File: rtl/scan_channel_mux.sv
// Registered N-channel sample selector: manual select or round-robin scan over an enable mask with dwell.
// Latency: 1 cycle from InValid to OutValid/Out/OutChan.
// Backpressure: Out held while OutValid & !OutReady; InValid arriving with no space is dropped silently.
module scan_channel_mux
  import dsp_mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS),
  parameter int DWELL    = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [WIDTH*CHANNELS-1:0] InBus,
  input  logic                      InValid,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Sel,
  input  logic [CHANNELS-1:0]       ChanEn,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          OutChan,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      SelErr
);

  // Lanes and mask are padded to the full select range so out-of-range Sel reads a disabled, zero lane.
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  typedef logic [NSLOT-1:0] slot_mask_t;

  logic [WIDTH-1:0] lane [NSLOT];
  slot_mask_t       en_ext;

  logic [WIDTH-1:0] out_q;
  logic [SEL_W-1:0] chan_q, ptr_q, ptr_d, nxt_ptr, ch;
  logic [7:0]       cnt_q, cnt_d, cnt_eff;
  logic             vld_q, err_q, err_d, mode_q;
  logic             scan, space, take, legal, load, any_en;

  for (genvar k = 0; k < NSLOT; k++) begin : g_lane
    if (k < CHANNELS) begin : g_real
      assign lane[k] = InBus[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign lane[k] = '0;
    end
  end

  assign en_ext = slot_mask_t'(ChanEn);

  rr_next_channel #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_next (
    .ptr_i    (ptr_q),
    .mask_i   (ChanEn),
    .nxt_o    (nxt_ptr),
    .any_en_o (any_en)
  );

  // Load decision, error detection and scan pointer/dwell next-state.
  always_comb begin
    scan    = (Mode == MODE_SCAN);
    space   = !vld_q || OutReady;
    take    = InValid && space;
    // Entering scan starts a fresh dwell on the retained pointer.
    cnt_eff = (scan && (mode_q == MODE_MANUAL)) ? 8'd0 : cnt_q;
    ch      = scan ? ptr_q : Sel;
    legal   = en_ext[ch];
    load    = take && legal;
    err_d   = take && (scan ? !any_en : !legal);
    ptr_d   = ptr_q;
    cnt_d   = cnt_eff;
    if (scan && take) begin
      if (legal) begin
        if (cnt_eff == DWELL_LAST) begin
          cnt_d = 8'd0;
          ptr_d = nxt_ptr;
        end else begin
          cnt_d = cnt_eff + 8'd1;
        end
      end else if (any_en) begin
        // Pointer sits on a channel that was masked off: skip ahead, new channel gets a full dwell.
        ptr_d = nxt_ptr;
        cnt_d = 8'd0;
      end
    end
  end

  // Output register, handshake and scan state with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_q  <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= 8'd0;
      mode_q <= MODE_MANUAL;
    end else begin
      if (load) begin
        out_q  <= lane[ch];
        chan_q <= ch;
        vld_q  <= 1'b1;
      end else if (OutReady) begin
        vld_q  <= 1'b0;
      end
      err_q  <= err_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      mode_q <= Mode;
    end
  end

  assign Out      = out_q;
  assign OutChan  = chan_q;
  assign OutValid = vld_q;
  assign SelErr   = err_q;

endmodule
